// File: rtl/of_drain_pkg.sv
// of_drain_pkg: shared types and helpers for the output-feature-map drain stage.
package of_drain_pkg;

    localparam int unsigned OF_DATA_WIDTH = 8;

    // One serialised output word (two operand widths)
    typedef logic [2*OF_DATA_WIDTH-1:0] of_word_t;

    // Serialiser states. LOAD marks the cycle decision that moves a head
    // vector's word 0 into the output register; it is never held across an edge.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } fsm_state_t;

    // Width of the column index for a vector of n words
    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/of_drain_vec_fifo.sv
// vec_fifo: whole-vector FIFO. Owns pointers, occupancy count and full/empty.
// A push while full is ignored, so a same-cycle pop cannot make room for it.
module vec_fifo #(
    parameter int unsigned X_DIM  = 15,
    parameter int unsigned WORD_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WORD_W-1:0]        push_vec [X_DIM],
    input  logic                     pop,
    output logic [WORD_W-1:0]        head_vec [X_DIM],
    output logic [WORD_W-1:0]        next_word0,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH][X_DIM];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_ptr_nxt;
    logic              push_ok;
    logic              pop_ok;

    assign full       = (count == (PW+1)'(DEPTH));
    assign empty      = (count == '0);
    assign push_ok    = push && !full;
    assign pop_ok     = pop && !empty;
    assign rd_ptr_nxt = rd_ptr + 1'b1;
    assign head_vec   = mem[rd_ptr];
    assign next_word0 = mem[rd_ptr_nxt][0];

    // Pointer and occupancy bookkeeping; pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Vector storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_vec;
        end
    end

endmodule

// File: rtl/of_drain.sv
// of_drain: captures X_DIM parallel pe_out words into a vector FIFO and
// serialises each vector into a one-word valid/ready stream.
// Optional feature macro: OF_DRAIN_RELU_EN (clamp negative words to zero on capture).
module of_drain
    import of_drain_pkg::*;
#(
    parameter int unsigned X_DIM      = 15,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cap_valid,
    output logic                          cap_ready,
    input  logic [2*DATA_WIDTH-1:0]       pe_in [X_DIM],
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*DATA_WIDTH-1:0]       out_data,
    output logic [idx_width(X_DIM)-1:0]   out_idx,
    output logic                          out_last,
    output logic                          ovf,
    input  logic                          ovf_clr
);

    localparam int unsigned WW = 2*DATA_WIDTH;
    localparam int unsigned IW = idx_width(X_DIM);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(X_DIM - 1);

    logic [WW-1:0] cap_vec  [X_DIM];
    logic [WW-1:0] head_vec [X_DIM];
    logic [WW-1:0] next_word0;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    fsm_state_t    state_q;
    fsm_state_t    state_d;
    fsm_state_t    mode;

    logic          valid_d;
    logic [WW-1:0] data_d;
    logic [IW-1:0] idx_d;
    logic          last_d;
    logic [IW-1:0] idx_inc;

    assign cap_ready = !fifo_full;
    assign push      = cap_valid && cap_ready;
    assign idx_inc   = out_idx + 1'b1;

    // Condition captured words on the way into the FIFO (no added latency)
    always_comb begin
        for (int unsigned i = 0; i < X_DIM; i++) begin
`ifdef OF_DRAIN_RELU_EN
            cap_vec[i] = pe_in[i][WW-1] ? '0 : pe_in[i];
`else
            cap_vec[i] = pe_in[i];
`endif
        end
    end

    vec_fifo #(
        .X_DIM  (X_DIM),
        .WORD_W (WW),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_vec   (cap_vec),
        .pop        (pop),
        .head_vec   (head_vec),
        .next_word0 (next_word0),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Serialiser state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, pop decision and this cycle's action (mode)
    always_comb begin
        state_d = state_q;
        mode    = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    mode    = LOAD;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_valid && out_ready && out_last) begin
                    pop = 1'b1;
                    // count is pre-capture, so a vector arriving now is not chained
                    if (fifo_count > CW'(1)) begin
                        mode = LOAD;
                    end else begin
                        mode    = IDLE;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                mode    = IDLE;
                state_d = IDLE;
            end
        endcase
    end

    // Output register next values driven by the chosen action
    always_comb begin
        valid_d = out_valid;
        data_d  = out_data;
        idx_d   = out_idx;
        last_d  = out_last;
        case (mode)
            LOAD: begin
                valid_d = 1'b1;
                data_d  = (state_q == IDLE) ? head_vec[0] : next_word0;
                idx_d   = '0;
                last_d  = 1'b0;
            end
            STREAM: begin
                if (out_valid && out_ready) begin
                    data_d = head_vec[idx_inc];
                    idx_d  = idx_inc;
                    last_d = (idx_inc == LAST_IDX);
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= valid_d;
            out_data  <= data_d;
            out_idx   <= idx_d;
            out_last  <= last_d;
        end
    end

    // Sticky overflow flag; a new drop outranks a same-cycle clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (cap_valid && !cap_ready) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_of_drain.sv
// tb_of_drain: scoreboard bench for of_drain (X_DIM=15, DATA_WIDTH=8, FIFO_DEPTH=4).
module tb_of_drain;
    import of_drain_pkg::*;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cap_valid;
    logic        cap_ready;
    logic [15:0] pe_in [15];
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        ovf;
    logic        ovf_clr;

    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        sb[$];

    of_drain #(
        .X_DIM      (15),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .pe_in     (pe_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic of_word_t exp_word(input of_word_t w);
`ifdef OF_DRAIN_RELU_EN
        return w[15] ? 16'h0000 : w;
`else
        return w;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fill_vec(input logic [15:0] base);
        for (int i = 0; i < 15; i++) pe_in[i] = base + 16'(i);
    endtask

    task automatic push_vec();
        exp_t e;
        for (int i = 0; i < 15; i++) begin
            e.d    = exp_word(pe_in[i]);
            e.idx  = 4'(i);
            e.last = (i == 14);
            sb.push_back(e);
        end
    endtask

    task automatic capture(input logic [15:0] base);
        fill_vec(base);
        push_vec();
        cap_valid = 1'b1;
        @(posedge clk); #1;
        cap_valid = 1'b0;
    endtask

    task automatic drain(input bit toggle, input int budget);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < budget) begin
            out_ready = toggle ? ~out_ready : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check("drain_left", 32'(sb.size()) | 32'(out_valid), 32'd0);
        out_ready = 1'b1;
    endtask

    // Monitor: pops expected words on each handshake and checks hold stability
    logic        stall_q = 1'b0;
    logic [20:0] held;
    always @(negedge clk) begin
        if (!rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                checks++;
                if (!out_valid || {out_data, out_idx, out_last} !== held) begin
                    errors++;
                    $display("FAIL hold actual=%0h/%0b required=%0h/1", {out_data, out_idx, out_last}, out_valid, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none", {out_data, out_idx, out_last});
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({out_data, out_idx, out_last} !== e) begin
                        errors++;
                        $display("FAIL word actual=%h/%0d/%0b required=%h/%0d/%0b",
                                 out_data, out_idx, out_last, e.d, e.idx, e.last);
                    end
                end
            end
            stall_q = out_valid && !out_ready;
            held    = {out_data, out_idx, out_last};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cap_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        fill_vec(16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_cap_ready", 32'(cap_ready), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single vector: 1-cycle latency, 15 consecutive words
        out_ready = 1'b1;
        capture(16'h0100);
        check("single_lat0", 32'(out_valid), 32'd0);
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            check("single_valid", 32'(out_valid), 32'd1);
            if (c == 0) check("single_first_idx", 32'(out_idx), 32'd0);
        end
        @(posedge clk); #1;
        check("single_end_valid", 32'(out_valid), 32'd0);
        check("single_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure: out_ready toggles every cycle
        out_ready = 1'b0;
        capture(16'h0A00);
        drain(1'b1, 80);

        // Fill and overflow; 5th capture also asserts ovf_clr (set wins)
        out_ready = 1'b0;
        for (int v = 0; v < 5; v++) begin
            fill_vec(16'h1000 + 16'(v) * 16'h0100);
            cap_valid = 1'b1;
            ovf_clr   = (v == 4);
            check("fill_cap_ready", 32'(cap_ready), (v < 4) ? 32'd1 : 32'd0);
            if (v < 4) push_vec();
            @(posedge clk); #1;
        end
        cap_valid = 1'b0;
        ovf_clr   = 1'b0;
        check("fill_ovf_set", 32'(ovf), 32'd1);
        check("fill_full", 32'(cap_ready), 32'd0);
        drain(1'b0, 100);
        check("ovf_sticky", 32'(ovf), 32'd1);
        check("drain_cap_ready", 32'(cap_ready), 32'd1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);

        // Back-to-back drain: 30 valid cycles without a bubble
        out_ready = 1'b0;
        capture(16'h2000);
        capture(16'h2100);
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            check("b2b_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        check("b2b_end_valid", 32'(out_valid), 32'd0);
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-stream at word 7 of the first vector
        out_ready = 1'b0;
        capture(16'h3000);
        capture(16'h3100);
        out_ready = 1'b1;
        begin
            int n = 0;
            while (!(out_valid && out_idx == 4'd7) && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            check("rst_mid_reach7", 32'(out_valid && out_idx == 4'd7), 32'd1);
        end
        rst = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_cap_ready", 32'(cap_ready), 32'd1);
        check("rst_mid_idx", 32'(out_idx), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("rst_mid_no_stale", 32'(out_valid), 32'd0);
        end

        // Sign handling (clamped only when ReLU is compiled in)
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) pe_in[i] = (i % 2 == 1) ? (16'h8000 | 16'(i)) : (16'h0040 + 16'(i));
        pe_in[0] = 16'hFFF0;
        pe_in[1] = 16'h0010;
        push_vec();
        cap_valid = 1'b1;
        @(posedge clk); #1;
        cap_valid = 1'b0;
        drain(1'b0, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/of_drain.md
# of_drain

Output-feature-map drain stage that sits directly downstream of `pe_array`. It captures the X_DIM parallel `pe_out` words when the array controller strobes them valid and buffers whole vectors in a small FIFO. It then serialises each vector into a single-word valid/ready stream toward the output buffer. This decouples the array's parallel result timing from the narrower output-buffer write port.

## Interface
- `X_DIM`, 15: number of parallel `pe_out` words per vector; must be ≥ 2.
- `DATA_WIDTH`, 8: PE operand width; each output word is 2*DATA_WIDTH bits.
- `FIFO_DEPTH`, 4: number of whole vectors buffered; power of two, ≥ 2.
- `clk` input, 1: single clock; all state updates on its rising edge.
- `rst` input, 1: reset, asynchronous, active-low.
- `cap_valid` input, 1: `pe_in` holds a valid result vector this cycle.
- `cap_ready` output, 1: FIFO can accept a vector (not full).
- `pe_in` input, X_DIM × 2*DATA_WIDTH: unpacked array fed from `pe_array.pe_out`.
- `out_valid` output, 1: `out_data` is valid.
- `out_ready` input, 1: downstream accepts the word.
- `out_data` output, 2*DATA_WIDTH: serialised word.
- `out_idx` output, $clog2(X_DIM): column index of `out_data`.
- `out_last` output, 1: high with index X_DIM-1.
- `ovf` output, 1: sticky flag; set when `cap_valid && !cap_ready`.
- `ovf_clr` input, 1: synchronous clear of `ovf`.

## Operation
- **Capture.** On `cap_valid && cap_ready`, write `pe_in` into the FIFO at the write pointer and increment the count. When `cap_valid` is high with `cap_ready` low, drop the vector, set `ovf`, and leave the FIFO unchanged.
- **`cap_ready`.** Equals `count != FIFO_DEPTH`, decoded from registered state. A pop in the same cycle does not make room for a same-cycle capture.
- **Pointers.** Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. `count` is one bit wider.
- **Serialiser FSM states:**
  - IDLE: output register empty.
  - LOAD: head vector present and output register empty or being consumed.
  - STREAM: emitting words.
- **IDLE → STREAM.** On the first edge with `count > 0`: load word 0 of the head vector, set `out_idx` = 0, assert `out_valid`.
- **Word handshake.** Each `out_valid && out_ready` advances `out_idx` and loads the next word.
  - On the handshake of word X_DIM-1: pop the head and decrement the count.
  - If the FIFO still holds another vector (excluding one captured this same cycle), load its word 0 with no bubble.
  - Otherwise go to IDLE and deassert `out_valid`.
- **Hold.** While `out_valid && !out_ready`, `out_data`, `out_idx` and `out_last` stay stable.
- **Simultaneous capture and pop** at count = FIFO_DEPTH: the capture is refused (`ovf` set). The count drops by one.
- **`ovf` precedence.** Set has priority over `ovf_clr` in the same cycle.
- **Arithmetic.** No width change. Words pass bit-exact unless the ReLU feature is compiled in.
- **Reset values.** `out_valid` = 0, `out_data` = 0, `out_idx` = 0, `out_last` = 0, `ovf` = 0, `cap_ready` = 1. Pointers, count and FSM are cleared. FIFO storage is not reset.
- **Reset mid-stream.** All buffered vectors are discarded, and `out_valid` drops asynchronously.

## Timing
- Capture at edge N with the FIFO previously empty → `out_valid` and word 0 visible after edge N+1. Latency is 1 cycle.
- Throughput: one word per cycle while `out_ready` is held high. One vector every X_DIM cycles.
- `cap_ready` deasserts the cycle after the capture that fills the FIFO. It reasserts the cycle after the pop of word X_DIM-1.
- Sustained: capture faster than once per X_DIM cycles eventually fills the FIFO.

## Configuration
- **`OF_DRAIN_RELU_EN` defined:** each captured word is treated as two's-complement. Negative words (MSB = 1) are stored as 0; non-negative words are stored unchanged. This adds no latency.
- **Undefined:** words are stored and emitted raw.

## Structure
- Shared package `of_drain_pkg`:
  - `of_word_t` (2*DATA_WIDTH logic vector).
  - The `fsm_state_t` enum.
  - A function for the index width, `$clog2(X_DIM)`.
- One sub-module, `vec_fifo`: a parameterised FIFO with the vector as entry type. It owns the pointers, the count and the full/empty flags. `of_drain` holds the serialiser FSM, the output register and `ovf`.

## Test plan
- **Single vector.** Capture `pe_in[i]` = 16'h0100+i with `out_ready` = 1 → words 0x0100..0x010E emitted on 15 consecutive cycles starting 1 cycle after capture. `out_last` is high only on 0x010E.
- **Backpressure.** Toggle `out_ready` 1/0 every cycle → every word appears in order, held stable while not ready. No duplicates or skips.
- **Fill and overflow.** 5 back-to-back captures with `out_ready` = 0, FIFO_DEPTH = 4 → `cap_ready` low after the 4th. The 5th is dropped and `ovf` = 1. Releasing `out_ready` yields exactly 4 vectors. Then `ovf_clr` → `ovf` = 0.
- **Back-to-back drain.** Two vectors queued, `out_ready` = 1 → 30 consecutive valid words, no bubble between index 14 and index 0.
- **Reset mid-stream.** Assert `rst` low at word 7 of vector 1 with 2 vectors queued → `out_valid` = 0 immediately, `cap_ready` = 1. After release, no stale words appear.
- **ReLU.** With `OF_DRAIN_RELU_EN`, capture 16'hFFF0 and 16'h0010 → 0x0000 and 0x0010. Without the macro → 0xFFF0 and 0x0010.
